balu_rs: RTL and testbench
==========================

// Module: balu_rs
// PURPOSE
//  Branch reservation station that feeds balu. Holds dispatched compare-branch ops until both
//  operands are valid, snooping the CDB for pending operands. Issues one ready op per cycle on
//  balu's rs_i/vl/vr/op inputs. Frees the entry when balu returns rs/taken, and reports the resolution.
// PARAMETERS
//  WIDTH  32  operand width; must match balu WIDTH
//  RSBIT  3   entry-id width; ids 1..(2**RSBIT)-1 are entries, id 0 = idle/none
//  TAGW   5   producer tag width on the CDB
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active-high
//  flush         in   1      discard all entries (mispredict/exception)
//  disp_valid    in   1      dispatch request
//  disp_ready    out  1      a free entry exists and no flush drain is in progress
//  disp_rs       out  RSBIT  id to be allocated this cycle (valid when disp_ready)
//  disp_op       in   3      BALU_* opcode
//  disp_vl       in   WIDTH  left operand value (when disp_vl_ok)
//  disp_vl_ok    in   1      left operand is valid; else wait on disp_vl_tag
//  disp_vl_tag   in   TAGW   producer tag of left operand
//  disp_vr       in   WIDTH  right operand value (when disp_vr_ok)
//  disp_vr_ok    in   1      right operand is valid; else wait on disp_vr_tag
//  disp_vr_tag   in   TAGW   producer tag of right operand
//  cdb_valid     in   1      result broadcast
//  cdb_tag       in   TAGW   broadcast tag
//  cdb_value     in   WIDTH  broadcast value
//  iss_rs        out  RSBIT  to balu rs_i; 0 = no issue
//  iss_op        out  3      to balu op
//  iss_vl        out  WIDTH  to balu vl
//  iss_vr        out  WIDTH  to balu vr
//  res_rs        in   RSBIT  from balu rs; 0 = no result
//  res_taken     in   1      from balu taken
//  done_valid    out  1      resolution pulse
//  done_rs       out  RSBIT  resolved entry id
//  done_taken    out  1      branch outcome
// BEHAVIOUR
//  - Reset: all entries FREE; iss_rs/op/vl/vr = 0; done_valid = done_rs = done_taken = 0; drain = 0.
//  - Entry states: FREE -> WAIT (operand missing) or RDY -> ISSUED -> FREE.
//  - Dispatch (disp_valid & disp_ready): allocate the lowest-numbered FREE entry; disp_rs is combinational from registered state.
//  - Dispatch capture: a not-ok operand whose tag matches a same-cycle CDB broadcast captures cdb_value (bypass).
//  - Wakeup: each WAIT entry captures cdb_value into every pending operand with matching tag. Entry becomes RDY when both are valid.
//  - Issue: select the lowest-index RDY entry from the state at the start of the cycle.
//    Register it onto iss_* at the edge and mark it ISSUED. With no RDY entry, iss_rs <= 0 (iss_vl/vr/op hold).
//    An op dispatched or woken in cycle t issues no earlier than edge t+1; balu returns res_rs at the following edge.
//  - Resolve: when res_rs != 0 and that entry is ISSUED, free it and register done_valid=1/done_rs/done_taken.
//    Otherwise done_valid <= 0. A res_rs naming a non-ISSUED entry is dropped.
//  - Free vs allocate in the same cycle: the freed entry is allocatable from the next cycle only.
//  - Full: disp_ready = 0. disp_valid while not ready is ignored (no state change).
//  - Flush: takes priority over dispatch/wakeup/issue/resolve in that cycle.
//    All entries go FREE; iss_rs <= 0; done_valid <= 0; drain counter <= 2.
//    While drain != 0, disp_ready = 0 and res_rs is ignored, so an in-flight balu result cannot hit a reallocated id. Drain decrements each cycle.
//  - Reset mid-operation: same end state as the reset values above; results arriving afterwards are dropped.
//  - Operand compare: values are stored raw; signedness and width semantics belong to balu.
// STRUCTURE
//  - global.inc: BALU_* opcodes (existing); add BRS_FREE/BRS_WAIT/BRS_RDY/BRS_ISSUED state encodings.
//  - Sub-module balu_rs_pick: parameterised lowest-index-first one-hot/encoded picker.
//    Used twice: once over FREE for allocation, once over RDY for issue.
//  - Entry storage: flat per-entry registers (state, op, vl, vr, vl_ok, vr_ok, tags); no RAM.
// TESTING
//  - Reset, then dispatch op=EQ vl=5 vr=5, both ok, at cycle 0
//    -> iss_rs=1 at edge 1; balu res_rs=1 taken=1 -> done_valid=1, done_rs=1, done_taken=1; entry 1 FREE.
//  - Dispatch LT with vr pending tag 3; CDB tag 3 value 9 two cycles later
//    -> no issue before the CDB edge; issue next cycle with iss_vr=9.
//  - Dispatch with vl pending tag 7 and CDB tag 7 value 0x20 in the same cycle
//    -> bypass capture; issue at next edge with iss_vl=0x20.
//  - Fill all 7 entries with a pending operand -> disp_ready=0; one result frees entry 4 -> next disp_rs=4.
//  - Flush with entry 2 ISSUED; balu returns res_rs=2 one cycle later
//    -> no done_valid; disp_ready low 2 cycles; then disp_rs=1.
//  - Three entries RDY in the same cycle (ids 2,5,6) -> iss_rs sequence 2,5,6 on consecutive edges.

Source files
------------

// File: rtl/balu_rs_pkg.sv
// Shared opcodes and entry-state encodings for the branch reservation station.
package balu_rs_pkg;

   localparam logic [2:0] BALU_EQ  = 3'd0;
   localparam logic [2:0] BALU_NE  = 3'd1;
   localparam logic [2:0] BALU_LT  = 3'd2;
   localparam logic [2:0] BALU_GE  = 3'd3;
   localparam logic [2:0] BALU_LTU = 3'd4;
   localparam logic [2:0] BALU_GEU = 3'd5;

   typedef enum logic [1:0] {
      BRS_FREE   = 2'd0,
      BRS_WAIT   = 2'd1,
      BRS_RDY    = 2'd2,
      BRS_ISSUED = 2'd3
   } brs_state_t;

   // Cycles after a flush during which results are ignored and dispatch is blocked.
   localparam logic [1:0] BRS_DRAIN_CYCLES = 2'd2;

endpackage

// File: rtl/balu_rs_pick.sv
// Lowest-index-first picker: one-hot grant plus zero-based encoded index.
module balu_rs_pick #(
   parameter int N  = 7,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan downward so the lowest set request is the last one to win.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IW'(i);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/balu_rs.sv
// Branch reservation station in front of balu: holds compare-branch ops until operands
// arrive on the CDB, issues one ready op per cycle, and frees entries on balu's result.
module balu_rs
   import balu_rs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RSBIT = 3,
   parameter int TAGW  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             disp_valid,
   output logic             disp_ready,
   output logic [RSBIT-1:0] disp_rs,
   input  logic [2:0]       disp_op,
   input  logic [WIDTH-1:0] disp_vl,
   input  logic             disp_vl_ok,
   input  logic [TAGW-1:0]  disp_vl_tag,
   input  logic [WIDTH-1:0] disp_vr,
   input  logic             disp_vr_ok,
   input  logic [TAGW-1:0]  disp_vr_tag,
   input  logic             cdb_valid,
   input  logic [TAGW-1:0]  cdb_tag,
   input  logic [WIDTH-1:0] cdb_value,
   output logic [RSBIT-1:0] iss_rs,
   output logic [2:0]       iss_op,
   output logic [WIDTH-1:0] iss_vl,
   output logic [WIDTH-1:0] iss_vr,
   input  logic [RSBIT-1:0] res_rs,
   input  logic             res_taken,
   output logic             done_valid,
   output logic [RSBIT-1:0] done_rs,
   output logic             done_taken
);

   localparam int NE = 2 ** RSBIT;

   // Entry id 0 means "none", so storage covers ids 1..NE-1 only.
   brs_state_t       state_reg  [1:NE-1];
   logic [2:0]       op_reg     [1:NE-1];
   logic [WIDTH-1:0] vl_reg     [1:NE-1];
   logic [WIDTH-1:0] vr_reg     [1:NE-1];
   logic             vl_ok_reg  [1:NE-1];
   logic             vr_ok_reg  [1:NE-1];
   logic [TAGW-1:0]  vl_tag_reg [1:NE-1];
   logic [TAGW-1:0]  vr_tag_reg [1:NE-1];

   logic [NE-1:1]    free_req, free_grant, rdy_req, iss_grant, res_hit;
   logic [RSBIT-1:0] free_idx, rdy_idx;
   logic             free_any, rdy_any;

   logic [1:0]       drain_reg;
   logic [RSBIT-1:0] iss_rs_reg, done_rs_reg;
   logic [2:0]       iss_op_reg;
   logic [WIDTH-1:0] iss_vl_reg, iss_vr_reg;
   logic             done_valid_reg, done_taken_reg;

   logic             disp_fire, res_ok, disp_vl_got, disp_vr_got;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_vl, sel_vr;

   balu_rs_pick #(.N(NE - 1), .IW(RSBIT)) u_pick_free (
      .req   (free_req),
      .grant (free_grant),
      .idx   (free_idx),
      .any   (free_any)
   );

   balu_rs_pick #(.N(NE - 1), .IW(RSBIT)) u_pick_rdy (
      .req   (rdy_req),
      .grant (iss_grant),
      .idx   (rdy_idx),
      .any   (rdy_any)
   );

   assign disp_ready  = free_any && (drain_reg == 2'd0);
   assign disp_rs     = disp_ready ? (free_idx + RSBIT'(1)) : '0;
   assign disp_fire   = disp_valid && disp_ready;
   assign res_ok      = (drain_reg == 2'd0) && (res_rs != '0);
   // A pending operand whose producer broadcasts in the dispatch cycle is captured directly.
   assign disp_vl_got = disp_vl_ok || (cdb_valid && (cdb_tag == disp_vl_tag));
   assign disp_vr_got = disp_vr_ok || (cdb_valid && (cdb_tag == disp_vr_tag));

   for (genvar gi = 1; gi < NE; gi++) begin : g_ent
      logic vl_wake, vr_wake;

      assign free_req[gi] = (state_reg[gi] == BRS_FREE);
      assign rdy_req[gi]  = (state_reg[gi] == BRS_RDY);
      assign res_hit[gi]  = res_ok && (res_rs == RSBIT'(gi)) && (state_reg[gi] == BRS_ISSUED);
      assign vl_wake      = cdb_valid && !vl_ok_reg[gi] && (cdb_tag == vl_tag_reg[gi]);
      assign vr_wake      = cdb_valid && !vr_ok_reg[gi] && (cdb_tag == vr_tag_reg[gi]);

      always_ff @(posedge clk) begin
         if (rst || flush) begin
            state_reg[gi] <= BRS_FREE;
         end else if (disp_fire && free_grant[gi]) begin
            state_reg[gi]  <= (disp_vl_got && disp_vr_got) ? BRS_RDY : BRS_WAIT;
            op_reg[gi]     <= disp_op;
            vl_reg[gi]     <= disp_vl_ok ? disp_vl : cdb_value;
            vr_reg[gi]     <= disp_vr_ok ? disp_vr : cdb_value;
            vl_ok_reg[gi]  <= disp_vl_got;
            vr_ok_reg[gi]  <= disp_vr_got;
            vl_tag_reg[gi] <= disp_vl_tag;
            vr_tag_reg[gi] <= disp_vr_tag;
         end else if (state_reg[gi] == BRS_WAIT) begin
            if (vl_wake) begin
               vl_reg[gi]    <= cdb_value;
               vl_ok_reg[gi] <= 1'b1;
            end
            if (vr_wake) begin
               vr_reg[gi]    <= cdb_value;
               vr_ok_reg[gi] <= 1'b1;
            end
            if ((vl_ok_reg[gi] || vl_wake) && (vr_ok_reg[gi] || vr_wake))
               state_reg[gi] <= BRS_RDY;
         end else if (iss_grant[gi]) begin
            state_reg[gi] <= BRS_ISSUED;
         end else if (res_hit[gi]) begin
            state_reg[gi] <= BRS_FREE;
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_vl = '0;
      sel_vr = '0;
      for (int i = 1; i < NE; i++) begin
         if (iss_grant[i]) begin
            sel_op = sel_op | op_reg[i];
            sel_vl = sel_vl | vl_reg[i];
            sel_vr = sel_vr | vr_reg[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iss_rs_reg     <= '0;
         iss_op_reg     <= '0;
         iss_vl_reg     <= '0;
         iss_vr_reg     <= '0;
         done_valid_reg <= 1'b0;
         done_rs_reg    <= '0;
         done_taken_reg <= 1'b0;
         drain_reg      <= '0;
      end else if (flush) begin
         iss_rs_reg     <= '0;
         done_valid_reg <= 1'b0;
         drain_reg      <= BRS_DRAIN_CYCLES;
      end else begin
         if (rdy_any) begin
            iss_rs_reg <= rdy_idx + RSBIT'(1);
            iss_op_reg <= sel_op;
            iss_vl_reg <= sel_vl;
            iss_vr_reg <= sel_vr;
         end else begin
            iss_rs_reg <= '0;
         end
         done_valid_reg <= |res_hit;
         if (|res_hit) begin
            done_rs_reg    <= res_rs;
            done_taken_reg <= res_taken;
         end
         if (drain_reg != 2'd0)
            drain_reg <= drain_reg - 2'd1;
      end
   end

   assign iss_rs     = iss_rs_reg;
   assign iss_op     = iss_op_reg;
   assign iss_vl     = iss_vl_reg;
   assign iss_vr     = iss_vr_reg;
   assign done_valid = done_valid_reg;
   assign done_rs    = done_rs_reg;
   assign done_taken = done_taken_reg;

endmodule

// File: tb/tb_balu_rs.sv
// Bench for balu_rs: directed scenarios plus randomized traffic against an entry-level model.
module tb_balu_rs;
   import balu_rs_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, disp_valid, disp_ready;
   logic [2:0]  disp_rs, disp_op, iss_rs, iss_op, res_rs, done_rs;
   logic [31:0] disp_vl, disp_vr, cdb_value, iss_vl, iss_vr;
   logic        disp_vl_ok, disp_vr_ok, cdb_valid, res_taken, done_valid, done_taken;
   logic [4:0]  disp_vl_tag, disp_vr_tag, cdb_tag;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   balu_rs #(.WIDTH(32), .RSBIT(3), .TAGW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rs(disp_rs), .disp_op(disp_op),
      .disp_vl(disp_vl), .disp_vl_ok(disp_vl_ok), .disp_vl_tag(disp_vl_tag),
      .disp_vr(disp_vr), .disp_vr_ok(disp_vr_ok), .disp_vr_tag(disp_vr_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .iss_rs(iss_rs), .iss_op(iss_op), .iss_vl(iss_vl), .iss_vr(iss_vr),
      .res_rs(res_rs), .res_taken(res_taken),
      .done_valid(done_valid), .done_rs(done_rs), .done_taken(done_taken)
   );

   // Reference model: a table of occupied entries, each holding its op and operands.
   bit          m_busy [8];
   bit          m_have_l [8];
   bit          m_have_r [8];
   bit          m_sent [8];
   logic [2:0]  m_op [8];
   logic [31:0] m_vl [8];
   logic [31:0] m_vr [8];
   logic [4:0]  m_tl [8];
   logic [4:0]  m_tr [8];
   int          m_drain;
   logic [2:0]  exp_iss_rs, exp_iss_op, exp_done_rs;
   logic [31:0] exp_iss_vl, exp_iss_vr;
   logic        exp_done_valid, exp_done_taken;

   function automatic int lowest_free();
      for (int i = 1; i < 8; i++) if (!m_busy[i]) return i;
      return 0;
   endfunction

   function automatic bit exp_ready();
      return (m_drain == 0) && (lowest_free() != 0);
   endfunction

   function automatic void model_step();
      int done_id, pick, alloc;
      bit can_disp;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 0;
         exp_iss_rs = 0; exp_iss_op = 0; exp_iss_vl = 0; exp_iss_vr = 0;
         exp_done_valid = 0; exp_done_rs = 0; exp_done_taken = 0; m_drain = 0;
         return;
      end
      if (flush) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 0;
         exp_iss_rs = 0; exp_done_valid = 0; m_drain = 2;
         return;
      end
      // All decisions use the table as it stood before this edge.
      done_id = (m_drain == 0 && res_rs != 0 && m_busy[res_rs] && m_sent[res_rs]) ? int'(res_rs) : 0;
      pick = 0;
      for (int i = 7; i >= 1; i--) if (m_busy[i] && !m_sent[i] && m_have_l[i] && m_have_r[i]) pick = i;
      alloc = lowest_free();
      can_disp = disp_valid && (alloc != 0) && (m_drain == 0);
      if (pick != 0) begin
         exp_iss_rs = 3'(pick); exp_iss_op = m_op[pick];
         exp_iss_vl = m_vl[pick]; exp_iss_vr = m_vr[pick];
         m_sent[pick] = 1;
      end else begin
         exp_iss_rs = 0;
      end
      exp_done_valid = (done_id != 0);
      if (done_id != 0) begin
         exp_done_rs = 3'(done_id); exp_done_taken = res_taken;
         m_busy[done_id] = 0;
      end
      for (int i = 1; i < 8; i++) begin
         if (m_busy[i] && cdb_valid) begin
            if (!m_have_l[i] && m_tl[i] == cdb_tag) begin m_have_l[i] = 1; m_vl[i] = cdb_value; end
            if (!m_have_r[i] && m_tr[i] == cdb_tag) begin m_have_r[i] = 1; m_vr[i] = cdb_value; end
         end
      end
      if (can_disp) begin
         m_busy[alloc] = 1; m_sent[alloc] = 0; m_op[alloc] = disp_op;
         m_tl[alloc] = disp_vl_tag; m_tr[alloc] = disp_vr_tag;
         m_have_l[alloc] = disp_vl_ok || (cdb_valid && cdb_tag == disp_vl_tag);
         m_have_r[alloc] = disp_vr_ok || (cdb_valid && cdb_tag == disp_vr_tag);
         m_vl[alloc] = disp_vl_ok ? disp_vl : cdb_value;
         m_vr[alloc] = disp_vr_ok ? disp_vr : cdb_value;
      end
      if (m_drain > 0) m_drain--;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_idle();
      rst = 0; flush = 0; disp_valid = 0; disp_op = 0;
      disp_vl = 0; disp_vl_ok = 0; disp_vl_tag = 0;
      disp_vr = 0; disp_vr_ok = 0; disp_vr_tag = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; res_rs = 0; res_taken = 0;
   endtask

   task automatic dispatch(input logic [2:0] op, input logic [31:0] vl, input bit lok, input logic [4:0] lt,
                           input logic [31:0] vr, input bit rok, input logic [4:0] rt);
      disp_valid = 1; disp_op = op;
      disp_vl = vl; disp_vl_ok = lok; disp_vl_tag = lt;
      disp_vr = vr; disp_vr_ok = rok; disp_vr_tag = rt;
   endtask

   task automatic drain_out();
      set_idle(); flush = 1; tick();
      set_idle(); tick(); tick();
   endtask

   task automatic test_reset();
      set_idle(); rst = 1; tick(); tick();
      vectors++; if (iss_rs !== 3'd0) begin miscompares++; $display("FAIL reset_iss_rs got %0d want 0", iss_rs); end
      vectors++; if (iss_op !== 3'd0) begin miscompares++; $display("FAIL reset_iss_op got %0d want 0", iss_op); end
      vectors++; if (iss_vl !== 32'd0 || iss_vr !== 32'd0) begin miscompares++; $display("FAIL reset_iss_vals got %h/%h want 0/0", iss_vl, iss_vr); end
      vectors++; if ({done_valid, done_rs, done_taken} !== 5'd0) begin miscompares++; $display("FAIL reset_done got %b/%0d/%b want 0/0/0", done_valid, done_rs, done_taken); end
      vectors++; if (disp_ready !== 1'b1 || disp_rs !== 3'd1) begin miscompares++; $display("FAIL reset_disp got ready=%b rs=%0d want 1/1", disp_ready, disp_rs); end
      set_idle();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      set_idle(); dispatch(BALU_EQ, 5, 1, 0, 5, 1, 0); tick();
      vectors++; if (iss_rs !== 3'd0) begin miscompares++; $display("FAIL basic_early got %0d want 0", iss_rs); end
      set_idle(); tick();
      vectors++; if (iss_rs !== 3'd1 || iss_op !== BALU_EQ || iss_vl !== 32'd5 || iss_vr !== 32'd5) begin miscompares++; $display("FAIL basic_issue got rs=%0d op=%0d vl=%0d vr=%0d want 1/0/5/5", iss_rs, iss_op, iss_vl, iss_vr); end
      res_rs = 1; res_taken = 1; tick();
      vectors++; if (done_valid !== 1'b1 || done_rs !== 3'd1 || done_taken !== 1'b1) begin miscompares++; $display("FAIL basic_done got %b/%0d/%b want 1/1/1", done_valid, done_rs, done_taken); end
      vectors++; if (disp_rs !== 3'd1) begin miscompares++; $display("FAIL basic_freed got %0d want 1", disp_rs); end
      set_idle(); tick();
      vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse got %b want 0", done_valid); end
      $display("test_basic done");
   endtask

   task automatic test_wakeup();
      set_idle(); dispatch(BALU_LT, 4, 1, 0, 0, 0, 3); tick();
      set_idle(); tick();
      vectors++; if (iss_rs !== 3'd0) begin miscompares++; $display("FAIL wake_wait got %0d want 0", iss_rs); end
      cdb_valid = 1; cdb_tag = 3; cdb_value = 9; tick();
      vectors++; if (iss_rs !== 3'd0) begin miscompares++; $display("FAIL wake_cdb_edge got %0d want 0", iss_rs); end
      set_idle(); tick();
      vectors++; if (iss_rs !== 3'd1 || iss_vr !== 32'd9 || iss_vl !== 32'd4 || iss_op !== BALU_LT) begin miscompares++; $display("FAIL wake_issue got rs=%0d vl=%0d vr=%0d op=%0d want 1/4/9/2", iss_rs, iss_vl, iss_vr, iss_op); end
      res_rs = 1; res_taken = 0; tick();
      vectors++; if (done_valid !== 1'b1 || done_taken !== 1'b0) begin miscompares++; $display("FAIL wake_done got %b/%b want 1/0", done_valid, done_taken); end
      set_idle(); tick();
      $display("test_wakeup done");
   endtask

   task automatic test_bypass();
      set_idle(); dispatch(BALU_GE, 0, 0, 7, 32'h11, 1, 0);
      cdb_valid = 1; cdb_tag = 7; cdb_value = 32'h20; tick();
      set_idle(); tick();
      vectors++; if (iss_rs !== 3'd1 || iss_vl !== 32'h20 || iss_vr !== 32'h11) begin miscompares++; $display("FAIL bypass got rs=%0d vl=%h vr=%h want 1/20/11", iss_rs, iss_vl, iss_vr); end
      res_rs = 1; tick();
      set_idle(); tick();
      $display("test_bypass done");
   endtask

   task automatic test_full();
      set_idle();
      for (int k = 1; k < 8; k++) begin
         vectors++; if (disp_rs !== 3'(k)) begin miscompares++; $display("FAIL full_alloc got %0d want %0d", disp_rs, k); end
         dispatch(BALU_NE, 32'(k), 0, 5'(8 + k), 32'(k), 1, 0); tick();
      end
      vectors++; if (disp_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b want 0", disp_ready); end
      dispatch(BALU_EQ, 1, 1, 0, 1, 1, 0); tick();
      set_idle(); cdb_valid = 1; cdb_tag = 12; cdb_value = 32'h44; tick();
      set_idle(); tick();
      vectors++; if (iss_rs !== 3'd4 || iss_vl !== 32'h44) begin miscompares++; $display("FAIL full_issue got rs=%0d vl=%h want 4/44", iss_rs, iss_vl); end
      res_rs = 4; res_taken = 1; tick();
      set_idle();
      vectors++; if (disp_ready !== 1'b1 || disp_rs !== 3'd4) begin miscompares++; $display("FAIL full_reuse got ready=%b rs=%0d want 1/4", disp_ready, disp_rs); end
      drain_out();
      $display("test_full done");
   endtask

   task automatic test_flush();
      set_idle(); dispatch(BALU_LT, 0, 0, 20, 0, 1, 0); tick();
      dispatch(BALU_EQ, 3, 1, 0, 3, 1, 0); tick();
      set_idle(); tick();
      vectors++; if (iss_rs !== 3'd2) begin miscompares++; $display("FAIL flush_pre got %0d want 2", iss_rs); end
      flush = 1; tick();
      vectors++; if (iss_rs !== 3'd0 || disp_ready !== 1'b0) begin miscompares++; $display("FAIL flush_edge got rs=%0d ready=%b want 0/0", iss_rs, disp_ready); end
      flush = 0; res_rs = 2; res_taken = 1; tick();
      vectors++; if (done_valid !== 1'b0 || disp_ready !== 1'b0) begin miscompares++; $display("FAIL flush_drain got done=%b ready=%b want 0/0", done_valid, disp_ready); end
      set_idle(); tick();
      vectors++; if (disp_ready !== 1'b1 || disp_rs !== 3'd1 || done_valid !== 1'b0) begin miscompares++; $display("FAIL flush_after got ready=%b rs=%0d done=%b want 1/1/0", disp_ready, disp_rs, done_valid); end
      $display("test_flush done");
   endtask

   task automatic test_back_to_back();
      logic [2:0] want [4];
      want[0] = 2; want[1] = 5; want[2] = 6; want[3] = 0;
      set_idle();
      for (int k = 1; k <= 6; k++) begin
         dispatch(BALU_GEU, 32'(k), 0, (k == 2 || k == 5 || k == 6) ? 5'd15 : 5'd14, 0, 1, 0); tick();
      end
      set_idle(); cdb_valid = 1; cdb_tag = 15; cdb_value = 32'h77; tick();
      set_idle();
      for (int k = 0; k < 4; k++) begin
         tick();
         vectors++; if (iss_rs !== want[k]) begin miscompares++; $display("FAIL b2b_seq[%0d] got %0d want %0d", k, iss_rs, want[k]); end
      end
      drain_out();
      $display("test_back_to_back done");
   endtask

   task automatic test_random(input int n);
      int s, j;
      for (int c = 0; c < n; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         flush = ($urandom_range(0, 39) == 0);
         disp_valid = 1'($urandom_range(0, 1)); disp_op = 3'($urandom_range(0, 5));
         disp_vl = $urandom; disp_vl_ok = ($urandom_range(0, 2) != 0); disp_vl_tag = 5'($urandom_range(0, 3));
         disp_vr = $urandom; disp_vr_ok = ($urandom_range(0, 2) != 0); disp_vr_tag = 5'($urandom_range(0, 3));
         cdb_valid = 1'($urandom_range(0, 1)); cdb_tag = 5'($urandom_range(0, 3)); cdb_value = $urandom;
         res_taken = 1'($urandom_range(0, 1));
         res_rs = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            s = $urandom_range(1, 7);
            for (int k = 0; k < 7; k++) begin
               j = 1 + ((s - 1 + k) % 7);
               if (m_busy[j] && m_sent[j]) begin res_rs = 3'(j); break; end
            end
         end
         tick();
         vectors++; if (iss_rs !== exp_iss_rs) begin miscompares++; $display("FAIL rnd_iss_rs c=%0d got %0d want %0d", c, iss_rs, exp_iss_rs); end
         if (exp_iss_rs != 0) begin
            vectors++; if (iss_op !== exp_iss_op || iss_vl !== exp_iss_vl || iss_vr !== exp_iss_vr) begin miscompares++; $display("FAIL rnd_iss_data c=%0d got %0d/%h/%h want %0d/%h/%h", c, iss_op, iss_vl, iss_vr, exp_iss_op, exp_iss_vl, exp_iss_vr); end
         end
         vectors++; if (done_valid !== exp_done_valid) begin miscompares++; $display("FAIL rnd_done_valid c=%0d got %b want %b", c, done_valid, exp_done_valid); end
         if (exp_done_valid) begin
            vectors++; if (done_rs !== exp_done_rs || done_taken !== exp_done_taken) begin miscompares++; $display("FAIL rnd_done c=%0d got %0d/%b want %0d/%b", c, done_rs, done_taken, exp_done_rs, exp_done_taken); end
         end
         vectors++; if (disp_ready !== exp_ready()) begin miscompares++; $display("FAIL rnd_ready c=%0d got %b want %b", c, disp_ready, exp_ready()); end
         if (exp_ready()) begin
            vectors++; if (disp_rs !== 3'(lowest_free())) begin miscompares++; $display("FAIL rnd_disp_rs c=%0d got %0d want %0d", c, disp_rs, lowest_free()); end
         end
      end
      set_idle(); tick();
      $display("test_random done (%0d cycles)", n);
   endtask

   initial begin
      set_idle();
      test_reset();
      test_basic();
      test_wakeup();
      test_bypass();
      test_full();
      test_flush();
      test_back_to_back();
      test_random(3000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
